// File: rtl/expipe_pkg.sv
// Shared execution-pipe types: instruction width, branch prediction, exception
// causes and the fetch queue entry layout.
package expipe_pkg;

   localparam int ILEN          = 32;
   localparam int FETCH_Q_DEPTH = 4;

   typedef struct packed {
      logic            taken;
      logic [ILEN-1:0] target;
   } prediction_t;

   typedef enum logic [3:0] {
      EXC_INSTR_MISALIGNED   = 4'd0,
      EXC_INSTR_ACCESS_FAULT = 4'd1,
      EXC_ILLEGAL_INSTR      = 4'd2,
      EXC_BREAKPOINT         = 4'd3,
      EXC_INSTR_PAGE_FAULT   = 4'd12
   } except_code_t;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      prediction_t     pred;
      logic            except;
      except_code_t    except_code;
   } fetch_queue_entry_t;

endpackage

// File: rtl/modn_counter.sv
// Modulo-N up-counter with enable and synchronous clear; used for the
// fetch queue head and tail pointers.
module modn_counter #(
   parameter int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] value_o
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         value_o <= '0;
      end else if (clr_i) begin
         value_o <= '0;
      end else if (en_i) begin
         value_o <= (value_o == W'(N - 1)) ? '0 : value_o + W'(1);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and issue. DEPTH must be a power of two >= 2.
// Once an excepting instruction is queued, intake stops until a flush.
module fetch_queue
   import expipe_pkg::*;
#(
   parameter int DEPTH = FETCH_Q_DEPTH,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             fetch_valid_i,
   output logic             fetch_ready_o,
   input  logic [ILEN-1:0]  fetch_instr_i,
   input  prediction_t      fetch_pred_i,
   input  logic             fetch_except_i,
   input  except_code_t     fetch_except_code_i,
   output logic             issue_valid_o,
   input  logic             issue_ready_i,
   output logic [ILEN-1:0]  issue_instr_o,
   output prediction_t      issue_pred_o,
   output logic             issue_except_o,
   output except_code_t     issue_except_code_o,
   output logic [CW-1:0]    count_o
);

   fetch_queue_entry_t mem [DEPTH];
   fetch_queue_entry_t wr_entry;
   fetch_queue_entry_t head_entry;
   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;
   logic               full;
   logic               exc_lock;
   logic               push;
   logic               pop;

   assign full          = (count_o == CW'(DEPTH));
   // Ready deliberately ignores issue_ready_i: a full queue never accepts,
   // even in a pop cycle, which keeps this path free of issue-side timing.
   assign fetch_ready_o = !full && !flush_i && !exc_lock;
   assign issue_valid_o = (count_o != '0);
   assign push          = fetch_valid_i && fetch_ready_o;
   assign pop           = issue_valid_o && issue_ready_i && !flush_i;

   assign wr_entry = '{instr:       fetch_instr_i,
                       pred:        fetch_pred_i,
                       except:      fetch_except_i,
                       except_code: fetch_except_code_i};

   modn_counter #(.N(DEPTH)) u_head_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (flush_i),
      .en_i    (pop),
      .value_o (head)
   );

   modn_counter #(.N(DEPTH)) u_tail_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (flush_i),
      .en_i    (push),
      .value_o (tail)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_o <= '0;
      end else if (flush_i) begin
         count_o <= '0;
      end else if (push && !pop) begin
         count_o <= count_o + CW'(1);
      end else if (pop && !push) begin
         count_o <= count_o - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         exc_lock <= 1'b0;
      end else if (flush_i) begin
         exc_lock <= 1'b0;
      end else if (push && fetch_except_i) begin
         exc_lock <= 1'b1;
      end
   end

   // Storage is cleared on reset so the head fields read as zero afterwards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[tail] <= wr_entry;
      end
   end

   assign head_entry          = mem[head];
   assign issue_instr_o       = head_entry.instr;
   assign issue_pred_o        = head_entry.pred;
   assign issue_except_o      = head_entry.except;
   assign issue_except_code_o = head_entry.except_code;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4) with hand-computed expectations.
module tb_fetch_queue;
   import expipe_pkg::*;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            flush_i = 1'b0;
   logic            fetch_valid_i = 1'b0;
   logic            fetch_ready_o;
   logic [ILEN-1:0] fetch_instr_i = '0;
   prediction_t     fetch_pred_i = '0;
   logic            fetch_except_i = 1'b0;
   except_code_t    fetch_except_code_i = EXC_INSTR_MISALIGNED;
   logic            issue_valid_o;
   logic            issue_ready_i = 1'b0;
   logic [ILEN-1:0] issue_instr_o;
   prediction_t     issue_pred_o;
   logic            issue_except_o;
   except_code_t    issue_except_code_o;
   logic [2:0]      count_o;

   int n_checks = 0;
   int n_fails  = 0;

   fetch_queue #(.DEPTH(4)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .flush_i             (flush_i),
      .fetch_valid_i       (fetch_valid_i),
      .fetch_ready_o       (fetch_ready_o),
      .fetch_instr_i       (fetch_instr_i),
      .fetch_pred_i        (fetch_pred_i),
      .fetch_except_i      (fetch_except_i),
      .fetch_except_code_i (fetch_except_code_i),
      .issue_valid_o       (issue_valid_o),
      .issue_ready_i       (issue_ready_i),
      .issue_instr_o       (issue_instr_o),
      .issue_pred_o        (issue_pred_o),
      .issue_except_o      (issue_except_o),
      .issue_except_code_o (issue_except_code_o),
      .count_o             (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // reset state
      #2;
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_valid", 64'(issue_valid_o), 64'd0);
      check("rst_ready", 64'(fetch_ready_o), 64'd1);
      check("rst_instr", 64'(issue_instr_o), 64'd0);
      check("rst_pred", 64'(issue_pred_o), 64'd0);
      check("rst_except", 64'(issue_except_o), 64'd0);
      check("rst_code", 64'(issue_except_code_o), 64'd0);
      tick();
      rst_i = 1'b0;
      tick();

      // first push, one-cycle latency
      fetch_valid_i = 1'b1;
      fetch_instr_i = 32'h0000_0013;
      fetch_pred_i  = '{taken: 1'b1, target: 32'h0000_0080};
      check("pre_push_valid", 64'(issue_valid_o), 64'd0);
      tick();
      fetch_pred_i = '0;
      check("push1_valid", 64'(issue_valid_o), 64'd1);
      check("push1_instr", 64'(issue_instr_o), 64'h13);
      check("push1_pred", 64'(issue_pred_o), {31'd0, 1'b1, 32'h80});
      check("push1_count", 64'(count_o), 64'd1);

      // fill to DEPTH
      for (int k = 0; k < 3; k++) begin
         fetch_instr_i = 32'h100 + 32'(k);
         tick();
      end
      check("full_count", 64'(count_o), 64'd4);
      check("full_ready", 64'(fetch_ready_o), 64'd0);

      // pop+push on full: only the pop happens
      fetch_instr_i = 32'hBAD;
      issue_ready_i = 1'b1;
      tick();
      fetch_valid_i = 1'b0;
      check("full_poppush_count", 64'(count_o), 64'd3);
      check("full_poppush_head", 64'(issue_instr_o), 64'h100);
      tick();
      check("drain_head1", 64'(issue_instr_o), 64'h101);
      tick();
      check("drain_head2", 64'(issue_instr_o), 64'h102);
      tick();
      check("drain_empty_count", 64'(count_o), 64'd0);
      check("drain_empty_valid", 64'(issue_valid_o), 64'd0);

      // streaming across pointer wrap
      fetch_valid_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         fetch_instr_i = 32'h200 + 32'(k);
         tick();
         check($sformatf("stream_instr%0d", k), 64'(issue_instr_o), 64'h200 + 64'(k));
         check($sformatf("stream_count%0d", k), 64'(count_o), 64'd1);
      end
      fetch_valid_i = 1'b0;
      tick();
      check("stream_end_count", 64'(count_o), 64'd0);

      // flush drops queued entries and the same-cycle push
      issue_ready_i = 1'b0;
      fetch_valid_i = 1'b1;
      fetch_instr_i = 32'h300;
      tick();
      fetch_instr_i = 32'h301;
      tick();
      check("preflush_count", 64'(count_o), 64'd2);
      flush_i = 1'b1;
      fetch_instr_i = 32'h3FF;
      #1;
      check("flush_ready", 64'(fetch_ready_o), 64'd0);
      tick();
      flush_i = 1'b0;
      fetch_valid_i = 1'b0;
      check("flush_count", 64'(count_o), 64'd0);
      check("flush_valid", 64'(issue_valid_o), 64'd0);
      tick();
      check("flush_stay_empty", 64'(issue_valid_o), 64'd0);
      fetch_valid_i = 1'b1;
      fetch_instr_i = 32'h400;
      tick();
      fetch_valid_i = 1'b0;
      check("postflush_head", 64'(issue_instr_o), 64'h400);
      check("postflush_count", 64'(count_o), 64'd1);
      issue_ready_i = 1'b1;
      tick();
      issue_ready_i = 1'b0;
      check("postflush_pop", 64'(count_o), 64'd0);

      // exception lock
      fetch_valid_i       = 1'b1;
      fetch_instr_i       = 32'h500;
      fetch_except_i      = 1'b1;
      fetch_except_code_i = EXC_INSTR_ACCESS_FAULT;
      tick();
      fetch_except_i      = 1'b0;
      fetch_except_code_i = EXC_INSTR_MISALIGNED;
      fetch_instr_i       = 32'h501;
      check("exc_ready", 64'(fetch_ready_o), 64'd0);
      check("exc_except", 64'(issue_except_o), 64'd1);
      check("exc_code", 64'(issue_except_code_o), 64'd1);
      tick();
      check("exc_blocked_count", 64'(count_o), 64'd1);
      issue_ready_i = 1'b1;
      tick();
      check("exc_popped_count", 64'(count_o), 64'd0);
      check("exc_still_locked", 64'(fetch_ready_o), 64'd0);
      fetch_valid_i = 1'b0;
      issue_ready_i = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      #1;
      check("exc_unlocked", 64'(fetch_ready_o), 64'd1);

      // asynchronous reset mid-stream
      fetch_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fetch_instr_i = 32'h600 + 32'(k);
         tick();
      end
      fetch_valid_i = 1'b0;
      check("prerst_count", 64'(count_o), 64'd3);
      #2 rst_i = 1'b1;
      #1;
      check("async_rst_count", 64'(count_o), 64'd0);
      check("async_rst_valid", 64'(issue_valid_o), 64'd0);
      check("async_rst_instr", 64'(issue_instr_o), 64'd0);
      #1 rst_i = 1'b0;
      tick();
      fetch_valid_i = 1'b1;
      fetch_instr_i = 32'h700;
      tick();
      fetch_valid_i = 1'b0;
      check("postrst_head", 64'(issue_instr_o), 64'h700);
      check("postrst_count", 64'(count_o), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
